// File: rtl/cordic_nco_if.sv
// cordic_nco_if: control and sample bus of the CORDIC NCO
// master drives ce, load, ampl, step, phase_ofs; slave returns out_valid, sin_wave, cos_wave
interface cordic_nco_if #(
    parameter int DATA_WIDTH  = 12,
    parameter int ANGLE_WIDTH = 16
);
    logic                          ce;
    logic                          load;
    logic        [DATA_WIDTH-1:0]  ampl;
    logic        [ANGLE_WIDTH-1:0] step;
    logic        [ANGLE_WIDTH-1:0] phase_ofs;
    logic                          out_valid;
    logic signed [DATA_WIDTH-1:0]  sin_wave;
    logic signed [DATA_WIDTH-1:0]  cos_wave;

    modport master (
        output ce, load, ampl, step, phase_ofs,
        input  out_valid, sin_wave, cos_wave
    );

    modport slave (
        input  ce, load, ampl, step, phase_ofs,
        output out_valid, sin_wave, cos_wave
    );
endinterface

// File: rtl/cordic_nco.sv
// cordic_nco: phase accumulator driving a fully unrolled rotation-mode CORDIC, amplitude-scaled quadrature out
// Ports: clk rising edge; reset async active-low; bus (cordic_nco_if.slave):
//   in  ce (global enable), load (acc clear + valid flush), ampl, step, phase_ofs
//   out out_valid, sin_wave = ampl*sin(phase), cos_wave = ampl*cos(phase)
// Option: CORDIC_NCO_DITHER_EN adds LFSR dither to the phase ahead of the quadrant fold.
module cordic_nco #(
    parameter int DATA_WIDTH  = 12,
    parameter int ANGLE_WIDTH = 16,
    parameter int STAGES      = 12
) (
    input logic         clk,
    input logic         reset,
    cordic_nco_if.slave bus
);
    localparam int W = DATA_WIDTH + 2;
    localparam int N = STAGES + 3;
    localparam logic        [DATA_WIDTH-1:0] AMAX = DATA_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [W-1:0]          SMAX = W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [W-1:0]          SMIN = -SMAX;

    // atan(2^-i) in phase units: integer arctan series in Q32 radians, then scaled by 2^32/(2*pi)
    function automatic logic [STAGES*ANGLE_WIDTH-1:0] atan_tab();
        logic [STAGES*ANGLE_WIDTH-1:0] tab;
        logic [63:0] a, t;
        tab = '0;
        tab[ANGLE_WIDTH-1:0] = ANGLE_WIDTH'(1) << (ANGLE_WIDTH - 3);
        for (int i = 1; i < STAGES; i++) begin
            a = '0;
            for (int k = 0; k < 16; k++)
                if (i * (2 * k + 1) < 32) begin
                    t = (64'd1 << (32 - i * (2 * k + 1))) / 64'(2 * k + 1);
                    a = k[0] ? a - t : a + t;
                end
            a = a * 64'd683565276;
            t = (a + (64'd1 << (63 - ANGLE_WIDTH))) >> (64 - ANGLE_WIDTH);
            tab[i*ANGLE_WIDTH +: ANGLE_WIDTH] = t[ANGLE_WIDTH-1:0];
        end
        return tab;
    endfunction

    localparam logic [STAGES*ANGLE_WIDTH-1:0] ATAN = atan_tab();

    // datapath carries one fractional bit; drop it with round-half-up, then clamp symmetrically
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        r = (v + W'(1)) >>> 1;
        r = r > SMAX ? SMAX : r < SMIN ? SMIN : r;
        return r[DATA_WIDTH-1:0];
    endfunction

    logic        [ANGLE_WIDTH-1:0] acc, phase, dith;
    logic        [N-1:0]           vsr;
    logic        [DATA_WIDTH+15:0] prod;
    logic signed [W-1:0]           x0;
    logic signed [W-1:0]           x [0:STAGES];
    logic signed [W-1:0]           y [0:STAGES];
    logic        [ANGLE_WIDTH-1:0] z [0:STAGES];
    logic        [DATA_WIDTH-1:0]  sin_r, cos_r;

`ifdef CORDIC_NCO_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            lfsr <= 16'hACE1;
        else if (bus.ce)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign dith = ANGLE_WIDTH'(lfsr[ANGLE_WIDTH/4-1:0]);
`else
    assign dith = '0;
`endif

    // 39797/2^16 ~ 1/K; shifting by 15 instead of 16 keeps the extra fractional bit
    always_comb begin
        prod = (bus.ampl > AMAX ? AMAX : bus.ampl) * 16'd39797;
        x0   = W'(prod >> 15);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc   <= '0;
            phase <= '0;
            vsr   <= '0;
            sin_r <= '0;
            cos_r <= '0;
            for (int s = 0; s <= STAGES; s++) begin
                x[s] <= '0;
                y[s] <= '0;
                z[s] <= '0;
            end
        end else if (bus.ce) begin
            acc   <= bus.load ? '0 : acc + bus.step;
            phase <= acc + bus.phase_ofs + dith;
            vsr   <= bus.load ? '0 : {vsr[N-2:0], 1'b1};
            x[0]  <= phase[ANGLE_WIDTH-2] ? '0 : phase[ANGLE_WIDTH-1] ? -x0 : x0;
            y[0]  <= phase[ANGLE_WIDTH-2] ? (phase[ANGLE_WIDTH-1] ? -x0 : x0) : '0;
            z[0]  <= {2'b00, phase[ANGLE_WIDTH-3:0]};
            for (int s = 0; s < STAGES; s++) begin
                x[s+1] <= z[s][ANGLE_WIDTH-1] ? x[s] + (y[s] >>> s) : x[s] - (y[s] >>> s);
                y[s+1] <= z[s][ANGLE_WIDTH-1] ? y[s] - (x[s] >>> s) : y[s] + (x[s] >>> s);
                z[s+1] <= z[s][ANGLE_WIDTH-1] ? z[s] + ATAN[s*ANGLE_WIDTH +: ANGLE_WIDTH]
                                              : z[s] - ATAN[s*ANGLE_WIDTH +: ANGLE_WIDTH];
            end
            cos_r <= round_sat(x[STAGES]);
            sin_r <= round_sat(y[STAGES]);
        end

    assign bus.out_valid = vsr[N-1];
    assign bus.sin_wave  = sin_r;
    assign bus.cos_wave  = cos_r;
endmodule

// File: tb/tb_cordic_nco.sv
// tb_cordic_nco: directed self-checking bench for cordic_nco
module tb_cordic_nco;
    localparam int DW  = 12;
    localparam int AW  = 16;
    localparam int ST  = 12;
    localparam int LAT = ST + 3;
`ifdef CORDIC_NCO_DITHER_EN
    localparam int TOL  = 4;
    localparam int TOLR = 4;
`else
    localparam int TOL  = 2;
    localparam int TOLR = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cordic_nco_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) bus ();

    cordic_nco #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .STAGES(ST)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic test_reset;
        int n, s, c;
        bus.ce = 1'b1;
        bus.load = 1'b0;
        bus.ampl = 12'd800;
        bus.step = '0;
        bus.phase_ofs = '0;
        reset = 1'b0;
        repeat (10) tick;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.sin_wave !== 12'sd0) begin errors++; $display("FAIL reset_sin got %0d want 0", bus.sin_wave); end
        checks++; if (bus.cos_wave !== 12'sd0) begin errors++; $display("FAIL reset_cos got %0d want 0", bus.cos_wave); end
        reset = 1'b1;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 4 * LAT) begin tick; n++; end
        checks++; if (n != LAT) begin errors++; $display("FAIL reset_latency got %0d want %0d", n, LAT); end
        s = bus.sin_wave;
        c = bus.cos_wave;
        checks++; if (iabs(s) > TOL) begin errors++; $display("FAIL t1_sin got %0d want 0", s); end
        checks++; if (iabs(c - 800) > TOL) begin errors++; $display("FAIL t1_cos got %0d want 800", c); end
    endtask

    task automatic test_quadrants;
        int ofs [4] = '{'h4000, 'h8000, 'hC000, 0};
        int es  [4] = '{800, 0, -800, 0};
        int ec  [4] = '{0, -800, 0, 800};
        int s, c;
        for (int i = 0; i < 4; i++) begin
            bus.phase_ofs = 16'(ofs[i]);
            repeat (LAT + 1) tick;
            s = bus.sin_wave;
            c = bus.cos_wave;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL quad_valid ofs=%h got %b want 1", ofs[i], bus.out_valid); end
            checks++; if (iabs(s - es[i]) > TOL) begin errors++; $display("FAIL quad_sin ofs=%h got %0d want %0d", ofs[i], s, es[i]); end
            checks++; if (iabs(c - ec[i]) > TOL) begin errors++; $display("FAIL quad_cos ofs=%h got %0d want %0d", ofs[i], c, ec[i]); end
        end
        tick;
        checks++; if (bus.sin_wave !== 12'(s) || bus.cos_wave !== 12'(c)) begin
            errors++; $display("FAIL step0_const got %0d/%0d want %0d/%0d", bus.sin_wave, bus.cos_wave, s, c);
        end
    endtask

    task automatic test_zero_ampl;
        bus.ampl = '0;
        bus.phase_ofs = 16'h2000;
        repeat (LAT + 1) tick;
        checks++; if (bus.sin_wave !== 12'sd0 || bus.cos_wave !== 12'sd0) begin
            errors++; $display("FAIL zero_ampl got %0d/%0d want 0/0", bus.sin_wave, bus.cos_wave);
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL zero_ampl_valid got %b want 1", bus.out_valid); end
        bus.ampl = 12'd800;
        bus.phase_ofs = '0;
    endtask

    task automatic test_sweep;
        int n, s, c, p, smax, smin, cmax;
        bus.ampl = 12'd800;
        bus.step = 16'd500;
        bus.phase_ofs = '0;
        bus.load = 1'b1;
        tick;
        bus.load = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sweep_flush got %b want 0", bus.out_valid); end
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 4 * LAT) begin tick; n++; end
        checks++; if (n != LAT) begin errors++; $display("FAIL load_latency got %0d want %0d", n, LAT); end
        smax = -9999; smin = 9999; cmax = -9999;
        for (int k = 0; k < 200; k++) begin
            s = bus.sin_wave;
            c = bus.cos_wave;
            p = (k * 500) % 65536;
            smax = s > smax ? s : smax;
            smin = s < smin ? s : smin;
            cmax = c > cmax ? c : cmax;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid k=%0d got %b want 1", k, bus.out_valid); end
            checks++; if (iabs(s * s + c * c - 640000) > 6400) begin
                errors++; $display("FAIL sweep_mag k=%0d got %0d want 640000+/-6400", k, s * s + c * c);
            end
            if (p >= 'h0800 && p <= 'h7800) begin
                checks++; if (s <= 0) begin errors++; $display("FAIL sweep_sin_sign p=%h got %0d want >0", p, s); end
            end else if (p >= 'h8800 && p <= 'hF800) begin
                checks++; if (s >= 0) begin errors++; $display("FAIL sweep_sin_sign p=%h got %0d want <0", p, s); end
            end
            if (p <= 'h3800 || p >= 'hC800) begin
                checks++; if (c <= 0) begin errors++; $display("FAIL sweep_cos_sign p=%h got %0d want >0", p, c); end
            end else if (p >= 'h4800 && p <= 'hB800) begin
                checks++; if (c >= 0) begin errors++; $display("FAIL sweep_cos_sign p=%h got %0d want <0", p, c); end
            end
            tick;
        end
        checks++; if (iabs(smax - 800) > TOL + 1) begin errors++; $display("FAIL peak_sin_max got %0d want 800", smax); end
        checks++; if (iabs(smin + 800) > TOL + 1) begin errors++; $display("FAIL peak_sin_min got %0d want -800", smin); end
        checks++; if (iabs(cmax - 800) > TOL + 1) begin errors++; $display("FAIL peak_cos_max got %0d want 800", cmax); end
    endtask

    task automatic test_load_restart;
        int n, s, c;
        bus.phase_ofs = 16'h4000;
        bus.load = 1'b1;
        tick;
        bus.load = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL restart_flush got %b want 0", bus.out_valid); end
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 4 * LAT) begin tick; n++; end
        checks++; if (n != LAT) begin errors++; $display("FAIL restart_latency got %0d want %0d", n, LAT); end
        s = bus.sin_wave;
        c = bus.cos_wave;
        checks++; if (iabs(s - 800) > TOL) begin errors++; $display("FAIL restart_sin got %0d want 800", s); end
        checks++; if (iabs(c) > TOL) begin errors++; $display("FAIL restart_cos got %0d want 0", c); end
        bus.phase_ofs = '0;
    endtask

    task automatic test_clamp;
        int n, s, c, p, smax, cmax;
        bus.ampl = 12'd4095;
        bus.step = 16'd500;
        bus.load = 1'b1;
        tick;
        bus.load = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 4 * LAT) begin tick; n++; end
        checks++; if (n != LAT) begin errors++; $display("FAIL clamp_latency got %0d want %0d", n, LAT); end
        smax = -9999; cmax = -9999;
        for (int k = 0; k < 140; k++) begin
            s = bus.sin_wave;
            c = bus.cos_wave;
            p = (k * 500) % 65536;
            smax = s > smax ? s : smax;
            cmax = c > cmax ? c : cmax;
            checks++; if (iabs(s) > 2047 || iabs(c) > 2047) begin errors++; $display("FAIL clamp_range k=%0d got %0d/%0d want <=2047", k, s, c); end
            if (p >= 'h0800 && p <= 'h7800) begin
                checks++; if (s <= 0) begin errors++; $display("FAIL clamp_sin_sign p=%h got %0d want >0", p, s); end
            end else if (p >= 'h8800 && p <= 'hF800) begin
                checks++; if (s >= 0) begin errors++; $display("FAIL clamp_sin_sign p=%h got %0d want <0", p, s); end
            end
            if (p <= 'h3800 || p >= 'hC800) begin
                checks++; if (c <= 0) begin errors++; $display("FAIL clamp_cos_sign p=%h got %0d want >0", p, c); end
            end else if (p >= 'h4800 && p <= 'hB800) begin
                checks++; if (c >= 0) begin errors++; $display("FAIL clamp_cos_sign p=%h got %0d want <0", p, c); end
            end
            tick;
        end
        checks++; if (smax < 2040) begin errors++; $display("FAIL clamp_peak_sin got %0d want >=2040", smax); end
        checks++; if (cmax < 2040) begin errors++; $display("FAIL clamp_peak_cos got %0d want >=2040", cmax); end
        bus.ampl = 12'd800;
    endtask

    task automatic test_load_ce_off;
        repeat (LAT + 1) tick;
        bus.ce = 1'b0;
        bus.load = 1'b1;
        tick;
        bus.ce = 1'b1;
        bus.load = 1'b0;
        tick;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL load_ce_off got %b want 1", bus.out_valid); end
    endtask

    task automatic test_ce_gating;
        int rs [40];
        int rc [40];
        int n, cyc, s, c, ps, pc;
        logic pv, e;
        bus.ampl = 12'd800;
        bus.step = 16'd777;
        bus.phase_ofs = 16'h1234;
        bus.ce = 1'b1;
        bus.load = 1'b1;
        tick;
        bus.load = 1'b0;
        n = 0; cyc = 0;
        while (n < 40 && cyc < 200) begin
            tick; cyc++;
            if (bus.out_valid === 1'b1) begin rs[n] = bus.sin_wave; rc[n] = bus.cos_wave; n++; end
        end
        checks++; if (n != 40) begin errors++; $display("FAIL ce_ref_count got %0d want 40", n); end
        bus.load = 1'b1;
        tick;
        bus.load = 1'b0;
        n = 0; cyc = 0;
        while (n < 40 && cyc < 1000) begin
            e = 1'($urandom_range(0, 1));
            bus.ce = e;
            ps = bus.sin_wave; pc = bus.cos_wave; pv = bus.out_valid;
            tick; cyc++;
            s = bus.sin_wave; c = bus.cos_wave;
            if (!e) begin
                checks++; if (s != ps || c != pc || bus.out_valid !== pv) begin
                    errors++; $display("FAIL ce_freeze got %0d/%0d/%b want %0d/%0d/%b", s, c, bus.out_valid, ps, pc, pv);
                end
            end else if (bus.out_valid === 1'b1) begin
                checks++; if (iabs(s - rs[n]) > TOLR || iabs(c - rc[n]) > TOLR) begin
                    errors++; $display("FAIL ce_sample n=%0d got %0d/%0d want %0d/%0d", n, s, c, rs[n], rc[n]);
                end
                n++;
            end
        end
        bus.ce = 1'b1;
        checks++; if (n != 40) begin errors++; $display("FAIL ce_gated_count got %0d want 40", n); end
    endtask

    task automatic test_reset_mid;
        int n;
        bus.step = 16'd500;
        repeat (LAT + 5) tick;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.sin_wave !== 12'sd0 || bus.cos_wave !== 12'sd0) begin
            errors++; $display("FAIL mid_reset_data got %0d/%0d want 0/0", bus.sin_wave, bus.cos_wave);
        end
        tick;
        reset = 1'b1;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 4 * LAT) begin tick; n++; end
        checks++; if (n != LAT) begin errors++; $display("FAIL mid_reset_latency got %0d want %0d", n, LAT); end
    endtask

    initial begin
        test_reset;
        test_quadrants;
        test_zero_ampl;
        test_sweep;
        test_load_restart;
        test_clamp;
        test_load_ce_off;
        test_ce_gating;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
